muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit with architectural HI/LO registers for the
//   multicycle MIPS datapath. Executes MULT/MULTU/DIV/DIVU on rs/rt operands.
//   hi/lo feed two inputs of the 8:1 write-back select, which serves MFHI/MFLO.
//   busy stalls the controller; done pulses when HI/LO hold the new result.
// PARAMETERS
//   WIDTH   32   operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous, active-high reset
//   start   in   1      launch op; sampled only when busy=0
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a       in   WIDTH  rs operand (multiplicand / dividend)
//   b       in   WIDTH  rt operand (multiplier / divisor)
//   mthi    in   1      write wdata into HI
//   mtlo    in   1      write wdata into LO
//   wdata   in   WIDTH  MTHI/MTLO data
//   hi      out  WIDTH  HI register (product[63:32] / remainder)
//   lo      out  WIDTH  LO register (product[31:0] / quotient)
//   busy    out  1      operation in progress
//   done    out  1      one-cycle pulse: hi/lo just updated by an op
// BEHAVIOUR
// - Reset: hi=0, lo=0, busy=0, done=0, state IDLE, counter=0. Reset mid-op aborts.
// - FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: start=1 at edge N latches op, |a|,|b| (magnitudes for signed ops),
//     result signs; counter=0; busy=1 from edge N.
//   RUN: one radix-2 step per edge (shift-add mult / restoring div);
//     counter increments; after WIDTH steps (edge N+WIDTH) -> FIX.
//   FIX: edge N+WIDTH+1 applies sign correction, writes hi/lo, busy=0, done=1
//     for exactly one cycle; -> IDLE.
// - Latency: result visible and done=1 after edge N+33 (WIDTH=32).
// - start while busy=1: ignored, no queueing. mthi/mtlo while busy: ignored.
// - IDLE, start and mthi/mtlo same edge: start wins; mthi/mtlo dropped.
// - IDLE, mthi and mtlo same edge: both registers written with wdata.
// - MULT: 2*WIDTH-bit two's-complement product. MULTU: unsigned product.
// - DIV: quotient truncates toward zero; remainder takes dividend's sign.
// - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
// - Divide by zero (DIV/DIVU): lo=0xFFFFFFFF, hi=a; same latency as any divide.
// - hi/lo hold old values throughout RUN; change only at FIX or mthi/mtlo.
// - done never asserts for mthi/mtlo writes.
// CONFIGURATION
//   MULDIV_FAST_MUL_EN defined: MULT/MULTU use a single-cycle WIDTHxWIDTH
//     multiplier; start at edge N writes hi/lo at edge N, busy stays 0,
//     done=1 in the cycle after edge N. Divides unchanged (iterative).
//   Undefined: all four ops iterative, 33-edge latency; no '*' operator inferred.
// TESTING
// 1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE lo=0x00000001,
//   done 1 cycle, busy high edges N..N+32.
// 2 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 ->
//   lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1).
// 3 DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=100; DIV 0x80000000/0xFFFFFFFF ->
//   lo=0x80000000 hi=0.
// 4 start DIVU 10/3, pulse start(MULTU 2*2) and mthi(wdata=0x55) at edge N+5 ->
//   both ignored; final hi=1 lo=3.
// 5 IDLE mthi=1 mtlo=1 wdata=0x1234 -> hi=lo=0x1234, done=0; rst at edge N+10
//   of a MULT -> hi=lo=0, busy=0 next cycle, no done.
// 6 MULDIV_FAST_MUL_EN: MULT 6*7 -> lo=42 hi=0 after edge N, busy never 1;
//   DIVU 42/6 still 33 edges, lo=7 hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// Signed operands are reduced to magnitudes at launch, processed with a
// radix-2 shift-add multiplier or restoring divider, and sign-corrected in
// a final FIX cycle. Optional macro MULDIV_FAST_MUL_EN replaces the
// iterative multiply with a single-cycle multiplier (divides stay iterative).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;
  localparam logic [CW-1:0]      CNT_ONE  = 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  // neg_lo: negate the full product (mult) or the quotient (div)
  logic               neg_lo_q, neg_lo_d;
  // neg_hi: negate the remainder (div only)
  logic               neg_hi_q, neg_hi_d;
  // opnd: multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // acc: {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand conditioning and launch values
  logic               is_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_load;
  logic [WIDTH-1:0]   opnd_load;
  logic               neg_lo_load, neg_hi_load;

  always_comb begin
    is_signed   = ~op[0];
    a_neg       = is_signed & a[WIDTH-1];
    b_neg       = is_signed & b[WIDTH-1];
    a_mag       = a_neg ? (~a + ONE_W) : a;
    b_mag       = b_neg ? (~b + ONE_W) : b;
    acc_load    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
    opnd_load   = op[1] ? b_mag : a_mag;
    // A zero divisor keeps the quotient positive so it lands as all ones
    neg_lo_load = op[1] ? ((a_neg ^ b_neg) & (b != '0)) : (a_neg ^ b_neg);
    neg_hi_load = op[1] & a_neg;
  end

  // One radix-2 step of each algorithm, selected later by is_div_q
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quot, fix_rem;

  always_comb begin
    fix_prod = neg_lo_q ? (~acc_q + ONE_2W) : acc_q;
    fix_quot = neg_lo_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    fix_rem  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
  end

`ifdef MULDIV_FAST_MUL_EN
  // Low 2*WIDTH bits of the sign-extended product equal the signed product
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    fast_prod = op[0] ? ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b})
                      : ({{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b});
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) begin
            hi_d   = fast_prod[2*WIDTH-1:WIDTH];
            lo_d   = fast_prod[WIDTH-1:0];
            done_d = 1'b1;
          end else begin
            state_d  = RUN;
            cnt_d    = '0;
            is_div_d = 1'b1;
            neg_lo_d = neg_lo_load;
            neg_hi_d = neg_hi_load;
            opnd_d   = opnd_load;
            acc_d    = acc_load;
          end
`else
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_lo_d = neg_lo_load;
          neg_hi_d = neg_hi_load;
          opnd_d   = opnd_load;
          acc_d    = acc_load;
`endif
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = fix_rem;
          lo_d = fix_quot;
        end else begin
          hi_d = fix_prod[2*WIDTH-1:WIDTH];
          lo_d = fix_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: operation table, busy/latency checks,
// ignored start/mthi while busy, MTHI/MTLO writes and mid-op reset.
// Honours MULDIV_FAST_MUL_EN for the expected multiply timing.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Drive one start pulse; returns just after the sampling edge (edge N)
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    logic [31:0] prev_hi;
    logic [1:0]  abort_op;

    vecs = '{
      '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
      '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{DIVU,  32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF},
      '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
      '{DIVU,  32'd42,       32'd6,        32'h00000000, 32'd7},
      '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
      '{MULT,  32'd6,        32'd7,        32'h00000000, 32'd42},
      '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF},
      '{DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999}
    };

    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    // Operation table
    for (int i = 0; i < 11; i++) begin
      logic fast_op;
      fast_op = FAST && !vecs[i].op[1];
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_start", i), {63'd0, busy}, {63'd0, !fast_op});
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), fast_op ? 64'd0 : 64'd33);
      check($sformatf("v%0d_busy_done", i), {63'd0, busy}, 64'd0);
      check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      @(posedge clk);
      #1 check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
    end

    // start and mthi while busy are ignored
    prev_hi = hi;
    launch(DIVU, 32'd10, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = MULTU; a = 32'd2; b = 32'd2; mthi = 1'b1; wdata = 32'h55;
    @(posedge clk);
    #1 start = 1'b0; mthi = 1'b0;
    check("busy_ign_hi_held", {32'd0, hi}, {32'd0, prev_hi});
    check("busy_ign_busy", {63'd0, busy}, 64'd1);
    wait_done(lat);
    check("busy_ign_latency", 64'(lat), 64'd28);
    check("busy_ign_hi", {32'd0, hi}, 64'd1);
    check("busy_ign_lo", {32'd0, lo}, 64'd3);
    repeat (3) @(posedge clk);
    #1 check("busy_ign_no_requeue", {63'd0, busy}, 64'd0);

    // Simultaneous MTHI/MTLO
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1 mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", {32'd0, hi}, 64'h1234);
    check("mthilo_lo", {32'd0, lo}, 64'h1234);
    check("mthilo_done", {63'd0, done}, 64'd0);

    // start wins over mtlo in the same edge
    @(negedge clk);
    op = DIVU; a = 32'd9; b = 32'd3; start = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
    @(posedge clk);
    #1 start = 1'b0; mtlo = 1'b0;
    check("start_wins_lo_held", {32'd0, lo}, 64'h1234);
    wait_done(lat);
    check("start_wins_lo", {32'd0, lo}, 64'd3);

    // Reset at edge N+10 aborts the operation
    abort_op = FAST ? DIVU : MULT;
    launch(abort_op, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 if (done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
